stopwatch_display: RTL
======================

STOPWATCH_DISPLAY -- requirements
Module: stopwatch_display

Interface
REQ-001 Parameter REFRESH_DIV, default 50000, clock cycles each digit is shown; legal range >= 2.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 enable  input  1  1 = display on; 0 = all anodes off while the scan keeps running.
REQ-005 minutes  input  6  binary minutes from the stopwatch time counter; valid range 0-59.
REQ-006 seconds  input  6  binary seconds from the stopwatch time counter; valid range 0-59.
REQ-007 anode  output  4  active-low digit enables, registered; bit0 = seconds ones, bit1 = seconds tens, bit2 = minutes ones, bit3 = minutes tens.
REQ-008 segments  output  7  active-low {g,f,e,d,c,b,a}, registered.
REQ-009 dp  output  1  active-low decimal point, registered.

Function
REQ-010 Refresh counter SHALL count 0..REFRESH_DIV-1 and wrap to 0; the wrap cycle is the "tick".
REQ-011 Digit index SHALL advance on each tick in the order 0,1,2,3,0.
REQ-012 A snapshot register SHALL capture minutes and seconds on each tick where the index wraps 3->0.
- Digit 0 displayed on that same edge SHALL use the newly captured values.
- Input changes mid-frame SHALL NOT affect digits 1-3 of the current frame.
REQ-013 On each tick, anode, segments and dp SHALL load the values for the new index in the same edge; between ticks they SHALL hold.
REQ-014 Binary-to-BCD conversion: tens = value/10, ones = value%10, for values 0-59.
REQ-015 Segment patterns:
- 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
- 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000
- dash=0111111, blank=1111111
REQ-016 A snapshot field >59 SHALL show dash on both digits of that field; the other field is unaffected.
REQ-017 dp SHALL be 0 while index = 2 (minutes/seconds separator) and 1 otherwise; it SHALL be forced to 1 when enable = 0.
REQ-018 With enable = 0, anode SHALL be 1111 on each tick; segments still update.
REQ-019 An enable change SHALL take effect at the next tick, not immediately.

Reset
REQ-020 While reset = 0, the block SHALL hold this state:
- refresh counter = 0, index = 0, snapshot = 00:00
- anode = 1111, segments = 1111111, dp = 1
REQ-021 Reset asserted mid-scan SHALL return all state to the reset state immediately, regardless of clock.
REQ-022 After reset deasserts, the first tick SHALL occur on the REFRESH_DIV-th rising edge.
- That tick SHALL capture a snapshot and show digit 0 (index wraps from reset state as 3->0 equivalent).

Configuration
REQ-023 Macro LEADING_ZERO_BLANK_EN:
- Defined: the minutes-tens digit SHALL show blank instead of 0 when snapshot minutes < 10.
- Undefined: that digit SHALL show 0.
- All other digits, including a dash for invalid minutes, are unaffected by the macro.

Verification
REQ-024 Benches SHALL use REFRESH_DIV = 4 and cover the following scenarios.
REQ-025 Reset, enable = 1, 12:34, release.
- Ticks every 4 cycles show anode/segments 1110/0011001, 1101/0110000, 1011/0100100 (dp = 0), 0111/1111001, then repeat.
REQ-026 Input 12:34 changed to 56:07 while digit 1 is showing.
- Digits 2 and 3 of the current frame still show 2 and 1.
- The next frame shows 7, 0, 6, 5.
REQ-027 seconds = 60, minutes = 3.
- Digits 0 and 1 show 0111111; digit 2 shows 0110000; digit 3 shows 0 (blank if LEADING_ZERO_BLANK_EN is defined).
REQ-028 enable dropped to 0 mid-frame.
- From the next tick: anode = 1111, dp = 1.
- Re-asserting enable resumes the scan at the current index without losing frame order.
REQ-029 Reset asserted asynchronously between clock edges while index = 2.
- Outputs go to 1111/1111111/1 at once.
- After release, the first tick is 4 edges later and shows digit 0.

Source files
------------

// File: rtl/stopwatch_display.sv
// stopwatch_display: multiplexed 4-digit 7-segment driver for an MM:SS stopwatch.
//
// Scans one digit every REFRESH_DIV clocks in the order seconds ones, seconds tens,
// minutes ones, minutes tens. At the start of each frame it snapshots the time, so
// the four digits of one frame always come from a single consistent time value.
// All display outputs are registered and change only on a scan tick.
//
// Ports:
//   clk_i       clock, rising edge
//   rst_ni      asynchronous active-low reset
//   enable_i    1 = display on, 0 = anodes off (scan continues); sampled on ticks
//   minutes_i   binary minutes 0-59 (values above 59 are shown as dashes)
//   seconds_i   binary seconds 0-59 (values above 59 are shown as dashes)
//   anode_o     active-low digit enables, bit0 = seconds ones .. bit3 = minutes tens
//   segments_o  active-low {g,f,e,d,c,b,a}
//   dp_o        active-low decimal point, lit on the minutes-ones digit
//
// Build option: define LEADING_ZERO_BLANK_EN to blank the minutes-tens digit when
// the minutes value is below 10.

module stopwatch_display #(
    parameter int unsigned REFRESH_DIV = 50000
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       enable_i,
    input  logic [5:0] minutes_i,
    input  logic [5:0] seconds_i,
    output logic [3:0] anode_o,
    output logic [6:0] segments_o,
    output logic       dp_o
);

    localparam int unsigned CntW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(REFRESH_DIV - 1);

    localparam logic [6:0] SegDash  = 7'b0111111;
    localparam logic [6:0] SegBlank = 7'b1111111;

    logic [CntW-1:0] cnt_q, cnt_d;
    logic [1:0]      idx_q, idx_d;
    logic            started_q, started_d;
    logic [5:0]      min_q, min_d;
    logic [5:0]      sec_q, sec_d;
    logic [3:0]      anode_q, anode_d;
    logic [6:0]      seg_q, seg_d;
    logic            dp_q, dp_d;

    logic            tick;
    logic            wrap;
    logic [6:0]      seg_new;

    function automatic logic [3:0] tens_of(input logic [5:0] v);
        if (v >= 6'd50)      return 4'd5;
        else if (v >= 6'd40) return 4'd4;
        else if (v >= 6'd30) return 4'd3;
        else if (v >= 6'd20) return 4'd2;
        else if (v >= 6'd10) return 4'd1;
        else                 return 4'd0;
    endfunction

    function automatic logic [3:0] ones_of(input logic [5:0] v);
        logic [5:0] r;
        r = v - 6'(tens_of(v)) * 6'd10;
        return r[3:0];
    endfunction

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = SegBlank;
        endcase
        return s;
    endfunction

    // Pattern for one digit of a field; an out-of-range field shows dash on both digits.
    function automatic logic [6:0] field_seg(input logic [5:0] v, input logic tens_sel);
        if (v > 6'd59) return SegDash;
        return seg_of(tens_sel ? tens_of(v) : ones_of(v));
    endfunction

    assign tick = (cnt_q == CntMax);
    // The first tick after reset behaves like a 3->0 wrap so it captures and shows digit 0.
    assign wrap = tick && (!started_q || (idx_q == 2'd3));

    always_comb begin
        cnt_d     = tick ? '0 : cnt_q + CntW'(1);
        started_d = started_q | tick;
        idx_d     = idx_q;
        min_d     = min_q;
        sec_d     = sec_q;
        if (tick) begin
            idx_d = wrap ? 2'd0 : idx_q + 2'd1;
        end
        if (wrap) begin
            min_d = minutes_i;
            sec_d = seconds_i;
        end
    end

    // Digit pattern for the index being entered, using the post-capture snapshot.
    always_comb begin
        seg_new = SegBlank;
        unique case (idx_d)
            2'd0: seg_new = field_seg(sec_d, 1'b0);
            2'd1: seg_new = field_seg(sec_d, 1'b1);
            2'd2: seg_new = field_seg(min_d, 1'b0);
            2'd3: begin
                seg_new = field_seg(min_d, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
                if (min_d < 6'd10) seg_new = SegBlank;
`endif
            end
        endcase
    end

    always_comb begin
        anode_d = anode_q;
        seg_d   = seg_q;
        dp_d    = dp_q;
        if (tick) begin
            seg_d   = seg_new;
            anode_d = enable_i ? ~(4'b0001 << idx_d) : 4'b1111;
            dp_d    = !(enable_i && (idx_d == 2'd2));
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q     <= '0;
            idx_q     <= 2'd0;
            started_q <= 1'b0;
            min_q     <= 6'd0;
            sec_q     <= 6'd0;
            anode_q   <= 4'b1111;
            seg_q     <= SegBlank;
            dp_q      <= 1'b1;
        end else begin
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            started_q <= started_d;
            min_q     <= min_d;
            sec_q     <= sec_d;
            anode_q   <= anode_d;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
        end
    end

    assign anode_o    = anode_q;
    assign segments_o = seg_q;
    assign dp_o       = dp_q;

endmodule
